// File: rtl/board_mem_arbiter.sv
// Board-state RAM arbiter: display reads win, game writes queue in a FIFO and drain in idle slots.
// Optional bulk clear sequencer is enabled with the BOARD_CLEAR_EN macro.
module board_mem_arbiter #(
  parameter int unsigned CELLS        = 196,
  parameter int unsigned AW           = 8,
  parameter int unsigned DW           = 2,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned STARVE_LIMIT = 1023
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          disp_req,
  input  logic [AW-1:0] disp_addr,
  output logic          disp_valid,
  output logic [DW-1:0] disp_data,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          clear_req,
  output logic          clear_done,
  output logic          busy,
  output logic          starve_err,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int unsigned   PW        = $clog2(FIFO_DEPTH);
  localparam int unsigned   SW        = $clog2(STARVE_LIMIT + 2);
  localparam logic [AW:0]   CellsW    = (AW+1)'(CELLS);
  localparam logic [PW:0]   DepthW    = (PW+1)'(FIFO_DEPTH);
  localparam logic [SW-1:0] StarveMax = SW'(STARVE_LIMIT + 1);

  logic [AW-1:0] fifo_addr_q [FIFO_DEPTH];
  logic [DW-1:0] fifo_data_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PW:0]   count_q, count_d;
  logic          wr_ready_q;
  logic          fifo_empty, push, pop;
  logic [AW-1:0] head_addr;
  logic [DW-1:0] head_data;
  logic          head_in_range;
  logic          idle, clr_step;
  logic [AW-1:0] clr_addr;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic          disp_valid_q, disp_oor_q;
  logic [SW-1:0] starve_cnt_q, starve_cnt_d;
  logic          starve_err_q;

`ifdef BOARD_CLEAR_EN
  typedef enum logic [1:0] {StIdle, StClear, StDone} state_e;
  state_e        state_q;
  logic [AW-1:0] clr_cnt_q;
  logic          clear_done_q;

  assign idle     = (state_q == StIdle);
  assign clr_step = (state_q == StClear) & ~disp_req & ~rst;
  assign clr_addr = clr_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      clr_cnt_q    <= '0;
      clear_done_q <= 1'b0;
    end else begin
      clear_done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (clear_req) begin
            state_q   <= StClear;
            clr_cnt_q <= '0;
          end
        end
        StClear: begin
          if (clr_step) begin
            if (clr_cnt_q == AW'(CELLS - 1)) begin
              state_q      <= StDone;
              clear_done_q <= 1'b1;
            end else begin
              clr_cnt_q <= clr_cnt_q + 1'b1;
            end
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign clear_done = clear_done_q;
`else
  logic unused_clear_req;
  assign unused_clear_req = clear_req;
  assign idle       = 1'b1;
  assign clr_step   = 1'b0;
  assign clr_addr   = '0;
  assign clear_done = 1'b0;
`endif

  // Write FIFO; pops only in idle slots, out-of-range heads are dropped silently.
  assign fifo_empty    = (count_q == '0);
  assign push          = wr_valid & wr_ready_q;
  assign head_addr     = fifo_addr_q[rd_ptr_q];
  assign head_data     = fifo_data_q[rd_ptr_q];
  assign head_in_range = ({1'b0, head_addr} < CellsW);
  assign pop           = idle & ~fifo_empty & ~disp_req & ~rst;
  assign count_d       = count_q + (PW+1)'(push) - (PW+1)'(pop);

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q] <= wr_addr;
      fifo_data_q[wr_ptr_q] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      wr_ready_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q    <= count_d;
      wr_ready_q <= (count_d != DepthW);
    end
  end

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (fifo_empty || pop) begin
      starve_cnt_d = '0;
    end else if (starve_cnt_q != StarveMax) begin
      starve_cnt_d = starve_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt_q <= '0;
      starve_err_q <= 1'b0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      starve_err_q <= starve_err_q | (starve_cnt_d == StarveMax);
    end
  end

  // RAM port is combinational so a read issued this cycle returns data next cycle.
  always_comb begin
    mem_addr  = addr_q;
    mem_we    = 1'b0;
    mem_wdata = wdata_q;
    if (rst) begin
      mem_addr  = '0;
      mem_wdata = '0;
    end else if (disp_req) begin
      mem_addr = disp_addr;
    end else if (clr_step) begin
      mem_addr  = clr_addr;
      mem_we    = 1'b1;
      mem_wdata = '0;
    end else if (pop && head_in_range) begin
      mem_addr  = head_addr;
      mem_we    = 1'b1;
      mem_wdata = head_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q       <= '0;
      wdata_q      <= '0;
      disp_valid_q <= 1'b0;
      disp_oor_q   <= 1'b0;
    end else begin
      addr_q       <= mem_addr;
      wdata_q      <= mem_wdata;
      disp_valid_q <= disp_req;
      disp_oor_q   <= ({1'b0, disp_addr} >= CellsW);
    end
  end

  assign disp_valid = disp_valid_q;
  assign disp_data  = (disp_valid_q && !disp_oor_q) ? mem_rdata : '0;
  assign wr_ready   = wr_ready_q;
  assign busy       = ~idle | ~fifo_empty;
  assign starve_err = starve_err_q;

endmodule

// File: tb/tb_board_mem_arbiter.sv
// Directed bench for board_mem_arbiter with a registered RAM model; clear tests need BOARD_CLEAR_EN.
module tb_board_mem_arbiter;
  localparam int unsigned AW = 8;
  localparam int unsigned DW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          disp_req;
  logic [AW-1:0] disp_addr;
  logic          disp_valid;
  logic [DW-1:0] disp_data;
  logic          wr_valid;
  logic          wr_ready;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          clear_req;
  logic          clear_done;
  logic          busy;
  logic          starve_err;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  int total = 0;
  int bad = 0;
  int we_cnt = 0;
  int acc, we_bad, dv_bad, base, cd, done_at, wc, zc;

  board_mem_arbiter #(
    .CELLS(196), .AW(AW), .DW(DW), .FIFO_DEPTH(4), .STARVE_LIMIT(15)
  ) dut (
    .clk(clk), .rst(rst),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_valid(disp_valid), .disp_data(disp_data),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .clear_req(clear_req), .clear_done(clear_done), .busy(busy), .starve_err(starve_err),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Registered RAM; every reset refills it with 3 so cleared or untouched cells are distinguishable.
  logic [DW-1:0] ram [256];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) ram[i] <= DW'(3);
    end else if (mem_we) begin
      ram[mem_addr] <= mem_wdata;
    end
    mem_rdata <= ram[mem_addr];
  end

  always @(negedge clk) if (mem_we) we_cnt++;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    step();
  endtask

  task automatic rd(input string tag, input int a, input int e);
    disp_req  = 1'b1;
    disp_addr = AW'(a);
    step();
    disp_req = 1'b0;
    #1;
    chk({tag, "_valid"}, disp_valid, 1);
    chk({tag, "_data"}, disp_data, e);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; disp_req = 1'b0; disp_addr = '0; wr_valid = 1'b0;
    wr_addr = '0; wr_data = '0; clear_req = 1'b0;

    // Reset values
    repeat (3) step();
    #1;
    chk("rst_wr_ready", wr_ready, 0);
    chk("rst_disp_valid", disp_valid, 0);
    chk("rst_disp_data", disp_data, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_starve", starve_err, 0);
    chk("rst_clear_done", clear_done, 0);
    rst = 1'b0;
    step(); #1;
    chk("ready_after_rst", wr_ready, 1);

    // Single write then read back
    wr_valid = 1'b1; wr_addr = 8'd5; wr_data = 2'd2;
    step();
    wr_valid = 1'b0; #1;
    chk("w1_we", mem_we, 1);
    chk("w1_addr", mem_addr, 5);
    chk("w1_wdata", mem_wdata, 2);
    chk("w1_busy", busy, 1);
    step(); #1;
    chk("w1_we_after", mem_we, 0);
    chk("w1_busy_after", busy, 0);
    disp_req = 1'b1; disp_addr = 8'd5; #1;
    chk("r1_mem_addr", mem_addr, 5);
    chk("r1_mem_we", mem_we, 0);
    step();
    disp_req = 1'b0; #1;
    chk("r1_valid", disp_valid, 1);
    chk("r1_data", disp_data, 2);
    step(); #1;
    chk("r1_valid_drop", disp_valid, 0);

    // Display priority and write buffering
    acc = 0; we_bad = 0; dv_bad = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      disp_req = 1'b1; disp_addr = 8'd7;
      wr_valid = (acc < 6); wr_addr = AW'(10 + acc); wr_data = DW'(acc % 3 + 1);
      #1;
      if (mem_we) we_bad++;
      if (i > 0 && !disp_valid) dv_bad++;
      if (wr_valid && wr_ready) acc++;
    end
    chk("buf_accepted", acc, 4);
    chk("buf_we_during_disp", we_bad, 0);
    chk("buf_back_to_back", dv_bad, 0);
    chk("buf_ready_full", wr_ready, 0);
    for (int k = 0; k < 6; k++) begin
      step();
      disp_req = 1'b0;
      wr_valid = (acc < 6); wr_addr = AW'(10 + acc); wr_data = DW'(acc % 3 + 1);
      #1;
      chk("drain_we", mem_we, 1);
      chk("drain_addr", mem_addr, 10 + k);
      chk("drain_wdata", mem_wdata, k % 3 + 1);
      if (k == 0) chk("drain_no_bypass", wr_ready, 0);
      if (wr_valid && wr_ready) acc++;
    end
    step();
    wr_valid = 1'b0; #1;
    chk("buf_accepted_total", acc, 6);
    chk("buf_idle", busy, 0);

    // Starvation with STARVE_LIMIT=15
    do_reset();
    disp_req = 1'b1; disp_addr = 8'd0;
    wr_valid = 1'b1; wr_addr = 8'd20; wr_data = 2'd1;
    for (int k = 1; k <= 20; k++) begin
      step();
      wr_valid = 1'b0; #1;
      if (k == 5) chk("starve_no_we", mem_we, 0);
      if (k == 16) chk("starve_pre", starve_err, 0);
      if (k == 17) chk("starve_rise", starve_err, 1);
    end
    disp_req = 1'b0; #1;
    chk("starve_drain_we", mem_we, 1);
    chk("starve_drain_addr", mem_addr, 20);
    step(); #1;
    chk("starve_sticky", starve_err, 1);
    chk("starve_busy", busy, 0);

    // Out-of-range write and read
    do_reset();
    base = we_cnt;
    wr_valid = 1'b1; wr_addr = 8'd200; wr_data = 2'd2;
    step();
    wr_valid = 1'b0; #1;
    chk("oor_busy", busy, 1);
    chk("oor_we", mem_we, 0);
    step(); #1;
    chk("oor_popped", busy, 0);
    chk("oor_we_cnt", we_cnt - base, 0);
    chk("oor_ram", ram[200], 3);
    rd("oor_rd", 250, 0);
    rd("inr_rd", 150, 3);

`ifdef BOARD_CLEAR_EN
    // Bulk clear with one display read mid-clear
    do_reset();
    wr_data = 2'd1;
    wr_valid = 1'b1; wr_addr = 8'd0;   step();
    wr_valid = 1'b1; wr_addr = 8'd100; step();
    wr_valid = 1'b1; wr_addr = 8'd195; step();
    wr_valid = 1'b0;
    repeat (3) step();
    rd("fill100", 100, 1);
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    done_at = 0; wc = 0; zc = 0;
    for (int n = 1; n <= 400 && done_at == 0; n++) begin
      disp_req = (n == 50); disp_addr = 8'd3;
      #1;
      if (mem_we) wc++;
      if (mem_we && mem_wdata == '0) zc++;
      if (n == 1) chk("clr_busy", busy, 1);
      if (clear_done) done_at = n;
      step();
    end
    disp_req = 1'b0; #1;
    chk("clr_done_cycle", done_at, 198);
    chk("clr_done_pulse", clear_done, 0);
    chk("clr_we_count", wc, 196);
    chk("clr_zero_count", zc, 196);
    chk("clr_busy_after", busy, 0);
    rd("clr0", 0, 0);
    rd("clr100", 100, 0);
    rd("clr195", 195, 0);
`else
    // Clear request must be ignored
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    base = we_cnt; cd = 0;
    repeat (5) begin
      #1;
      if (clear_done) cd++;
      step();
    end
    chk("clr_ignored_done", cd, 0);
    chk("clr_ignored_busy", busy, 0);
    chk("clr_ignored_we", we_cnt - base, 0);
`endif

    // Reset with writes pending
    do_reset();
    disp_req = 1'b1; disp_addr = 8'd1;
    wr_valid = 1'b1; wr_addr = 8'd30; wr_data = 2'd2; step();
    wr_addr = 8'd31; step();
    wr_valid = 1'b0; #1;
    chk("rstp_busy_before", busy, 1);
    rst = 1'b1; disp_req = 1'b0;
    base = we_cnt;
    step(); step();
    rst = 1'b0;
    repeat (5) step();
    #1;
    chk("rstp_we", we_cnt - base, 0);
    chk("rstp_busy", busy, 0);

`ifdef BOARD_CLEAR_EN
    // Reset mid-clear
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    repeat (10) step();
    rst = 1'b1;
    base = we_cnt;
    step(); step();
    rst = 1'b0;
    cd = 0;
    repeat (250) begin
      step(); #1;
      if (clear_done) cd++;
    end
    chk("rstc_we", we_cnt - base, 0);
    chk("rstc_done", cd, 0);
    chk("rstc_busy", busy, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
